writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter HIST_DEPTH, default 2, number of committed write-events kept for bypass lookup; legal range 1..4.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 stall  input  1  pipeline stall; high holds stage register and suppresses commit.
REQ-005 in_valid  input  1  memory-stage result valid.
REQ-006 in_is_load  input  1  destination data comes from in_load_data, else in_alu_result.
REQ-007 in_load_data, in_alu_result  input  32 each  candidate destination values.
REQ-008 in_dest_wen, in_dest  input  1, 5  primary destination write request and register.
REQ-009 in_addr_wen, in_addr_reg, in_addr_val  input  1, 5, 32  pre/post-increment base-register update.
REQ-010 in_halt  input  1  instruction is a halt.
REQ-011 wen0, waddr0, wdata0  output  1, 5, 32  register-file port 0 (primary destination).
REQ-012 wen1, waddr1, wdata1  output  1, 5, 32  register-file port 1 (address update).
REQ-013 q_addr0, q_addr1  input  5 each  bypass query addresses from decode.
REQ-014 q_hit0, q_data0, q_hit1, q_data1  output  1, 32 per port  bypass result.
REQ-015 halted  output  1  sticky halt-committed flag.
REQ-016 retired  output  32  count of committed instructions.

Function
REQ-017 Stage register (valid, selected data, dest, wens, addr fields, halt) SHALL load from inputs on a rising edge when stall=0, hold when stall=1.
REQ-018 Data select SHALL occur before registering: in_is_load ? in_load_data : in_alu_result.
REQ-019 Commit SHALL occur in any cycle where the stage register is valid, stall=0, halted=0; writes go out combinationally from the stage register in that cycle (one cycle after capture).
REQ-020 wen0 SHALL be 1 only on commit with dest_wen=1 and dest!=0.
REQ-021 wen1 SHALL be 1 only on commit with addr_wen=1, addr_reg!=0, and not (wen0=1 and addr_reg=dest); collision drops port 1, load/ALU data wins.
REQ-022 waddr*/wdata* SHALL mirror the stage register regardless of wen*.
REQ-023 On commit, each enabled port write SHALL be pushed into a HIST_DEPTH-deep history, newest first, oldest discarded; port 0 entry newer than port 1 entry of the same commit.
REQ-024 q_hit[n] SHALL be 1 when q_addr[n]!=0 and matches the current-cycle enabled write (wen0/wen1) or any valid history entry; q_data[n] from the newest match, current write highest priority; q_hit=0 gives q_data=0.
REQ-025 retired SHALL increment by 1 on every commit, wrapping 0xFFFFFFFF->0.
REQ-026 A commit with halt=1 SHALL perform its writes and set halted on that edge; halted=1 suppresses all later commits, writes, retired increments until reset.
REQ-027 Stall and commit are mutually exclusive; a stalled valid entry commits exactly once, after stall falls.

Reset
REQ-028 rst=1 at an edge SHALL clear stage valid, all history entries, halted, retired; outputs wen0=wen1=0, q_hit*=0, q_data*=0, addr/data outputs 0.
REQ-029 rst SHALL dominate stall and in_valid; an entry captured but uncommitted is discarded.

Structure
REQ-030 Shared package holds REG_W=5, XLEN=32, and the history-entry record (valid, addr, data).
REQ-031 One sub-module, wb_bypass_hist, holds the history shift array and priority lookup; instantiated once, two query ports.

Verification
REQ-032 ALU op dest=r5 value 0x1234 -> next cycle wen0=1 waddr0=5 wdata0=0x1234, wen1=0, retired=1.
REQ-033 Load dest=r7 data 0xAA, addr_wen r7 val 0x104 -> wen0=1 r7=0xAA, wen1=0; q_addr0=7 hits 0xAA.
REQ-034 Dest=r0 with addr_wen r2=0x200 -> wen0=0, wen1=1 waddr1=2 wdata1=0x200; q_addr=0 never hits.
REQ-035 Valid entry captured then stall high 3 cycles -> no writes during stall, single commit cycle after release, retired +1 only.
REQ-036 Writes r3=1, r3=2, r4=9 back-to-back (HIST_DEPTH=2) -> q_addr0=3 returns 2 (newest), q_addr1=4 returns 9; after one more unrelated write r3 ages out of depth, q_hit for r3=0.
REQ-037 Halt commit with dest r1=5 then further valid ops -> r1 written, halted=1, no later wen, retired frozen; rst clears halted and retired to 0.

Source files
------------

// File: rtl/writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_pkg
// Description : Shared widths, stage-register and history-entry records
//               for the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_pkg;

    localparam int REG_W = 5;
    localparam int XLEN  = 32;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] addr;
        logic [XLEN-1:0]  data;
    } hist_entry_t;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  data;
        logic             dest_wen;
        logic [REG_W-1:0] dest;
        logic             addr_wen;
        logic [REG_W-1:0] addr_reg;
        logic [XLEN-1:0]  addr_val;
        logic             halt;
    } stage_t;

endpackage
`default_nettype wire

// File: rtl/wb_bypass_hist.sv
`default_nettype none
// ============================================================================
// Module      : wb_bypass_hist
// Description : Shift history of committed register writes with two
//               priority bypass query ports (current write beats history).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_bypass_hist
    import writeback_pkg::*;
#(
    parameter int HIST_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0,
    input  logic [REG_W-1:0] addr0,
    input  logic [XLEN-1:0]  data0,
    input  logic             push1,
    input  logic [REG_W-1:0] addr1,
    input  logic [XLEN-1:0]  data1,
    input  logic [REG_W-1:0] q_addr0,
    input  logic [REG_W-1:0] q_addr1,
    output logic             q_hit0,
    output logic [XLEN-1:0]  q_data0,
    output logic             q_hit1,
    output logic [XLEN-1:0]  q_data1
);

    localparam int c_EXT_N = HIST_DEPTH + 2;

    hist_entry_t      r_hist_q [HIST_DEPTH];
    hist_entry_t      w_hist_d [HIST_DEPTH];
    hist_entry_t      w_ext    [c_EXT_N];
    hist_entry_t      w_cand   [c_EXT_N];
    hist_entry_t      w_new0;
    hist_entry_t      w_new1;
    logic [REG_W-1:0] w_qa     [2];
    logic             w_hit    [2];
    logic [XLEN-1:0]  w_data   [2];

    always_comb begin
        w_new0 = '{valid: push0, addr: addr0, data: data0};
        w_new1 = '{valid: push1, addr: addr1, data: data1};
        // A lone push always lands in slot 1 so one shift amount covers both ports.
        w_ext[0] = w_new0;
        w_ext[1] = push1 ? w_new1 : w_new0;
        w_cand[0] = w_new0;
        w_cand[1] = w_new1;
        for (int k = 0; k < HIST_DEPTH; k++) begin
            w_ext[k+2]  = r_hist_q[k];
            w_cand[k+2] = r_hist_q[k];
        end
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (push0 && push1)      w_hist_d[i] = w_ext[i];
            else if (push0 || push1) w_hist_d[i] = w_ext[i+1];
            else                     w_hist_d[i] = w_ext[i+2];
        end
    end

    always_comb begin
        w_qa[0] = q_addr0;
        w_qa[1] = q_addr1;
        for (int p = 0; p < 2; p++) begin
            w_hit[p]  = 1'b0;
            w_data[p] = '0;
            // Scan oldest to newest so the newest match is left standing.
            for (int k = c_EXT_N - 1; k >= 0; k--) begin
                if (w_cand[k].valid && (w_cand[k].addr == w_qa[p]) && (w_qa[p] != '0)) begin
                    w_hit[p]  = 1'b1;
                    w_data[p] = w_cand[k].data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < HIST_DEPTH; i++) r_hist_q[i] <= '0;
        end else begin
            for (int i = 0; i < HIST_DEPTH; i++) r_hist_q[i] <= w_hist_d[i];
        end
    end

    assign q_hit0  = w_hit[0];
    assign q_data0 = w_data[0];
    assign q_hit1  = w_hit[1];
    assign q_data1 = w_data[1];

endmodule
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
// Module      : writeback
// Description : Writeback stage: stage register, dual register-file write
//               ports, bypass history, halt latch and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback
    import writeback_pkg::*;
#(
    parameter int HIST_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             in_valid,
    input  logic             in_is_load,
    input  logic [XLEN-1:0]  in_load_data,
    input  logic [XLEN-1:0]  in_alu_result,
    input  logic             in_dest_wen,
    input  logic [REG_W-1:0] in_dest,
    input  logic             in_addr_wen,
    input  logic [REG_W-1:0] in_addr_reg,
    input  logic [XLEN-1:0]  in_addr_val,
    input  logic             in_halt,
    output logic             wen0,
    output logic [REG_W-1:0] waddr0,
    output logic [XLEN-1:0]  wdata0,
    output logic             wen1,
    output logic [REG_W-1:0] waddr1,
    output logic [XLEN-1:0]  wdata1,
    input  logic [REG_W-1:0] q_addr0,
    input  logic [REG_W-1:0] q_addr1,
    output logic             q_hit0,
    output logic [XLEN-1:0]  q_data0,
    output logic             q_hit1,
    output logic [XLEN-1:0]  q_data1,
    output logic             halted,
    output logic [XLEN-1:0]  retired
);

    stage_t          r_stage_q;
    stage_t          w_stage_d;
    logic            r_halted_q;
    logic            w_halted_d;
    logic [XLEN-1:0] r_retired_q;
    logic [XLEN-1:0] w_retired_d;
    logic            w_commit;
    logic            w_wen0;
    logic            w_wen1;

    always_comb begin
        w_stage_d = r_stage_q;
        if (!stall) begin
            w_stage_d.valid    = in_valid;
            w_stage_d.data     = in_is_load ? in_load_data : in_alu_result;
            w_stage_d.dest_wen = in_dest_wen;
            w_stage_d.dest     = in_dest;
            w_stage_d.addr_wen = in_addr_wen;
            w_stage_d.addr_reg = in_addr_reg;
            w_stage_d.addr_val = in_addr_val;
            w_stage_d.halt     = in_halt;
        end

        w_commit = r_stage_q.valid && !stall && !r_halted_q;
        w_wen0   = w_commit && r_stage_q.dest_wen && (r_stage_q.dest != '0);
        // Base update loses to the primary destination on a register collision.
        w_wen1   = w_commit && r_stage_q.addr_wen && (r_stage_q.addr_reg != '0)
                   && !(w_wen0 && (r_stage_q.addr_reg == r_stage_q.dest));

        w_halted_d  = r_halted_q || (w_commit && r_stage_q.halt);
        w_retired_d = w_commit ? r_retired_q + 32'd1 : r_retired_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_q   <= '0;
            r_halted_q  <= 1'b0;
            r_retired_q <= '0;
        end else begin
            r_stage_q   <= w_stage_d;
            r_halted_q  <= w_halted_d;
            r_retired_q <= w_retired_d;
        end
    end

    wb_bypass_hist #(
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .push0   (w_wen0),
        .addr0   (r_stage_q.dest),
        .data0   (r_stage_q.data),
        .push1   (w_wen1),
        .addr1   (r_stage_q.addr_reg),
        .data1   (r_stage_q.addr_val),
        .q_addr0 (q_addr0),
        .q_addr1 (q_addr1),
        .q_hit0  (q_hit0),
        .q_data0 (q_data0),
        .q_hit1  (q_hit1),
        .q_data1 (q_data1)
    );

    assign wen0    = w_wen0;
    assign waddr0  = r_stage_q.dest;
    assign wdata0  = r_stage_q.data;
    assign wen1    = w_wen1;
    assign waddr1  = r_stage_q.addr_reg;
    assign wdata1  = r_stage_q.addr_val;
    assign halted  = r_halted_q;
    assign retired = r_retired_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback
// Description : Directed self-checking bench for the writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        in_valid;
    logic        in_is_load;
    logic [31:0] in_load_data;
    logic [31:0] in_alu_result;
    logic        in_dest_wen;
    logic [4:0]  in_dest;
    logic        in_addr_wen;
    logic [4:0]  in_addr_reg;
    logic [31:0] in_addr_val;
    logic        in_halt;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [4:0]  q_addr0;
    logic [4:0]  q_addr1;
    logic        q_hit0;
    logic [31:0] q_data0;
    logic        q_hit1;
    logic [31:0] q_data1;
    logic        halted;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback #(.HIST_DEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .in_valid      (in_valid),
        .in_is_load    (in_is_load),
        .in_load_data  (in_load_data),
        .in_alu_result (in_alu_result),
        .in_dest_wen   (in_dest_wen),
        .in_dest       (in_dest),
        .in_addr_wen   (in_addr_wen),
        .in_addr_reg   (in_addr_reg),
        .in_addr_val   (in_addr_val),
        .in_halt       (in_halt),
        .wen0          (wen0),
        .waddr0        (waddr0),
        .wdata0        (wdata0),
        .wen1          (wen1),
        .waddr1        (waddr1),
        .wdata1        (wdata1),
        .q_addr0       (q_addr0),
        .q_addr1       (q_addr1),
        .q_hit0        (q_hit0),
        .q_data0       (q_data0),
        .q_hit1        (q_hit1),
        .q_data1       (q_data1),
        .halted        (halted),
        .retired       (retired)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_is_load = 0; in_load_data = 0; in_alu_result = 0;
        in_dest_wen = 0; in_dest = 0; in_addr_wen = 0; in_addr_reg = 0;
        in_addr_val = 0; in_halt = 0;
    endtask

    task automatic drive(input logic is_load, input logic [31:0] ld, input logic [31:0] alu,
                         input logic dwen, input logic [4:0] dest,
                         input logic awen, input logic [4:0] areg, input logic [31:0] aval,
                         input logic halt);
        in_valid = 1; in_is_load = is_load; in_load_data = ld; in_alu_result = alu;
        in_dest_wen = dwen; in_dest = dest; in_addr_wen = awen; in_addr_reg = areg;
        in_addr_val = aval; in_halt = halt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; stall = 0; q_addr0 = 0; q_addr1 = 0;
        idle();
        tick(); tick();
        check("rst_wen0", {31'd0, wen0}, 32'd0);
        check("rst_wen1", {31'd0, wen1}, 32'd0);
        check("rst_waddr0", {27'd0, waddr0}, 32'd0);
        check("rst_wdata0", wdata0, 32'd0);
        check("rst_qhit0", {31'd0, q_hit0}, 32'd0);
        check("rst_qdata0", q_data0, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_retired", retired, 32'd0);
        rst = 0;

        // ALU write r5 = 0x1234
        drive(0, 32'h0, 32'h1234, 1, 5'd5, 0, 5'd0, 32'h0, 0);
        tick(); idle(); q_addr0 = 5; settle();
        check("alu_wen0", {31'd0, wen0}, 32'd1);
        check("alu_waddr0", {27'd0, waddr0}, 32'd5);
        check("alu_wdata0", wdata0, 32'h1234);
        check("alu_wen1", {31'd0, wen1}, 32'd0);
        check("alu_qhit_cur", {31'd0, q_hit0}, 32'd1);
        check("alu_qdata_cur", q_data0, 32'h1234);
        tick();
        check("alu_retired", retired, 32'd1);
        check("alu_wen0_after", {31'd0, wen0}, 32'd0);

        // Load r7 = 0xAA colliding with base update of r7
        drive(1, 32'hAA, 32'hDEAD, 1, 5'd7, 1, 5'd7, 32'h104, 0);
        tick(); idle(); q_addr0 = 7; settle();
        check("ld_wen0", {31'd0, wen0}, 32'd1);
        check("ld_waddr0", {27'd0, waddr0}, 32'd7);
        check("ld_wdata0", wdata0, 32'hAA);
        check("ld_wen1_dropped", {31'd0, wen1}, 32'd0);
        check("ld_qhit0", {31'd0, q_hit0}, 32'd1);
        check("ld_qdata0", q_data0, 32'hAA);
        tick(); q_addr1 = 5; settle();
        check("ld_hist_qdata0", q_data0, 32'hAA);
        check("ld_hist_qdata1", q_data1, 32'h1234);
        check("ld_retired", retired, 32'd2);

        // Dest r0 with base update r2 = 0x200
        drive(0, 32'h0, 32'h55, 1, 5'd0, 1, 5'd2, 32'h200, 0);
        tick(); idle(); q_addr0 = 0; q_addr1 = 2; settle();
        check("r0_wen0", {31'd0, wen0}, 32'd0);
        check("r0_wen1", {31'd0, wen1}, 32'd1);
        check("r0_waddr1", {27'd0, waddr1}, 32'd2);
        check("r0_wdata1", wdata1, 32'h200);
        check("r0_qhit0_zero", {31'd0, q_hit0}, 32'd0);
        check("r0_qdata0_zero", q_data0, 32'd0);
        check("r0_qdata1", q_data1, 32'h200);
        tick();
        check("r0_retired", retired, 32'd3);

        // Stall holds a captured entry for three cycles
        drive(0, 32'h0, 32'h99, 1, 5'd9, 0, 5'd0, 32'h0, 0);
        tick();
        drive(0, 32'h0, 32'hBAD, 1, 5'd10, 0, 5'd0, 32'h0, 0);
        stall = 1; settle();
        check("stall_wen0_c1", {31'd0, wen0}, 32'd0);
        tick();
        check("stall_wen0_c2", {31'd0, wen0}, 32'd0);
        tick();
        check("stall_wen0_c3", {31'd0, wen0}, 32'd0);
        tick();
        check("stall_retired", retired, 32'd3);
        stall = 0; idle(); settle();
        check("unstall_wen0", {31'd0, wen0}, 32'd1);
        check("unstall_waddr0", {27'd0, waddr0}, 32'd9);
        check("unstall_wdata0", wdata0, 32'h99);
        tick();
        check("unstall_retired", retired, 32'd4);
        check("unstall_no_repeat", {31'd0, wen0}, 32'd0);

        // History ordering and ageing: r3=1, r3=2, r4=9, then r6
        drive(0, 32'h0, 32'h1, 1, 5'd3, 0, 5'd0, 32'h0, 0); tick();
        drive(0, 32'h0, 32'h2, 1, 5'd3, 0, 5'd0, 32'h0, 0); tick();
        drive(0, 32'h0, 32'h9, 1, 5'd4, 0, 5'd0, 32'h0, 0); tick();
        idle(); tick();
        q_addr0 = 3; q_addr1 = 4; settle();
        check("hist_r3_hit", {31'd0, q_hit0}, 32'd1);
        check("hist_r3_newest", q_data0, 32'h2);
        check("hist_r4", q_data1, 32'h9);
        check("hist_retired", retired, 32'd7);
        drive(0, 32'h0, 32'h66, 1, 5'd6, 0, 5'd0, 32'h0, 0); tick();
        idle(); tick();
        check("age_r3_hit", {31'd0, q_hit0}, 32'd0);
        check("age_r3_data", q_data0, 32'd0);
        check("age_r4_kept", q_data1, 32'h9);
        check("age_retired", retired, 32'd8);

        // Both ports in one commit: r12 via port 0, r13 via port 1
        drive(0, 32'h0, 32'hC, 1, 5'd12, 1, 5'd13, 32'hD, 0);
        tick(); idle(); settle();
        check("dual_wen0", {31'd0, wen0}, 32'd1);
        check("dual_wen1", {31'd0, wen1}, 32'd1);
        check("dual_waddr1", {27'd0, waddr1}, 32'd13);
        tick(); q_addr0 = 13; q_addr1 = 12; settle();
        check("dual_q13", q_data0, 32'hD);
        check("dual_q12", q_data1, 32'hC);
        q_addr1 = 6; settle();
        check("dual_r6_aged", {31'd0, q_hit1}, 32'd0);
        check("dual_retired", retired, 32'd9);

        // Halt commit then further ops are suppressed
        drive(0, 32'h0, 32'h5, 1, 5'd1, 0, 5'd0, 32'h0, 1);
        tick();
        drive(0, 32'h0, 32'h88, 1, 5'd8, 0, 5'd0, 32'h0, 0); settle();
        check("halt_wen0", {31'd0, wen0}, 32'd1);
        check("halt_waddr0", {27'd0, waddr0}, 32'd1);
        check("halt_wdata0", wdata0, 32'h5);
        tick();
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_retired", retired, 32'd10);
        check("halt_no_wen0", {31'd0, wen0}, 32'd0);
        tick();
        check("halt_frozen", retired, 32'd10);
        check("halt_no_wen0_2", {31'd0, wen0}, 32'd0);
        rst = 1; tick(); rst = 0; idle(); settle();
        check("halt_rst_flag", {31'd0, halted}, 32'd0);
        check("halt_rst_retired", retired, 32'd0);
        check("halt_rst_wen0", {31'd0, wen0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
